// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment encodings are active-low, bit0=a through bit6=g.
package sseg_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // Entry [n] is the segment pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {GAP, DRIVE} scan_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  blank;
  } disp_frame_t;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display update port: the producer offers a frame of four nibbles plus a
// blank mask with valid/ready.
interface sseg_scan_ctrl_if;
  logic [15:0] upd_data;
  logic [3:0]  upd_blank;
  logic        upd_valid;
  logic        upd_ready;

  modport master (output upd_data, output upd_blank, output upd_valid, input upd_ready);
  modport slave  (input upd_data, input upd_blank, input upd_valid, output upd_ready);
endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit display scanner: blanking gap between digits, shadow-buffered
// updates that only take effect on frame boundaries, leading-zero blanking.
//   state | meaning
//   GAP   | leading cycles of a slot, all anodes off
//   DRIVE | remainder of the slot, anode dig on, its segments driven
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int SLOT_CYCLES = 100000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sseg_scan_ctrl_if.slave     upd,
  input  logic                lz_en,
  output logic [3:0]          an,
  output logic [6:0]          sseg,
  output logic                frame_tick
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  scan_state_t   state;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    dig;
  disp_frame_t   active;
  disp_frame_t   pending;
  logic          pend_flag;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic [3:0]    hi_zero;
  logic          digit_blank;
  logic          slot_end;
  logic          accept;

  assign upd.upd_ready = !pend_flag;
  assign accept        = upd.upd_valid && !pend_flag;
  assign slot_end      = (slot_cnt == SLOT_LAST);

  // hi_zero[i]: every nibble at index >= i is zero; digit 0 never qualifies.
  always_comb begin
    nib        = active.data[{dig, 2'b00} +: 4];
    hi_zero    = 4'b0000;
    hi_zero[3] = (active.data[15:12] == 4'h0);
    hi_zero[2] = hi_zero[3] && (active.data[11:8] == 4'h0);
    hi_zero[1] = hi_zero[2] && (active.data[7:4] == 4'h0);
    digit_blank = active.blank[dig] || (lz_en && hi_zero[dig]);
  end

  sseg_hex_decode u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GAP;
      slot_cnt   <= '0;
      dig        <= 2'd0;
      active     <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
      an         <= AN_OFF;
      sseg       <= SSEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        dig      <= dig + 2'd1;
        state    <= GAP;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
        if (slot_cnt == GAP_LAST) state <= DRIVE;
      end

      if (state == GAP) begin
        an   <= AN_OFF;
        sseg <= SSEG_BLANK;
      end else begin
        an   <= ~(4'b0001 << dig);
        sseg <= digit_blank ? SSEG_BLANK : seg_dec;
      end

      frame_tick <= slot_end && (dig == 2'd3);

      // The registered frame_tick marks the boundary cycle, one cycle after
      // the last internal count of digit 3.
      if (frame_tick) begin
        if (pend_flag) begin
          active    <= pending;
          pend_flag <= 1'b0;
        end else if (accept) begin
          active <= '{data: upd.upd_data, blank: upd.upd_blank};
        end
      end else if (accept) begin
        pending   <= '{data: upd.upd_data, blank: upd.upd_blank};
        pend_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Time-multiplexing scheduler for the four-digit common-anode seven-segment display. It shares the single `sseg` bus between four digits by scanning `an` one digit at a time, with an inter-digit blanking gap to prevent ghosting. A valid/ready update port and a shadow register keep a frame from ever showing mixed old and new digits. It sits between the arithmetic/BCD datapath (producer of the digit nibbles) and the board pins.

## Interface
- `SLOT_CYCLES`, 100000: clock cycles per digit slot; legal range 2..2^20.
- `GAP_CYCLES`, 4: leading cycles of each slot with all anodes off; legal range 1..SLOT_CYCLES-1.
- `clk`  in  1  system clock; only clock domain.
- `rst_n`  in  1  reset: one clock, asynchronous assertion, active-low.
- `upd_data`  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `upd_blank`  in  4  per-digit force-blank mask, bit i blanks digit i.
- `upd_valid`  in  1  update offered.
- `upd_ready`  out  1  update can be accepted.
- `lz_en`  in  1  leading-zero suppression enable; live input, not buffered.
- `an`  out  4  anodes, active-low, one-hot-low or all-ones.
- `sseg`  out  7  segments, active-low, bit0=a … bit6=g.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of digit 3's slot.

## Operation
- Registers:
  - `active`: the displayed data and blank mask.
  - `pending`: the shadow copy, plus a pending flag.
  - `dig`: 2-bit digit index.
  - `slot_cnt`: counts 0..SLOT_CYCLES-1.
- Scan FSM states, per slot:
  - GAP: `slot_cnt` < GAP_CYCLES. Drives `an`=4'b1111 and `sseg`=7'h7F.
  - DRIVE: the rest of the slot. Drives `an` = ~(1<<dig) and `sseg` = the decode of active nibble `dig`.
  - At `slot_cnt`==SLOT_CYCLES-1: `slot_cnt`←0, `dig`←`dig`+1 (wraps 3→0), state←GAP.
- Decode, hex 0..F:
  - 0–7: 40,79,24,30,19,12,02,78.
  - 8–F: 00,10,08,03,46,21,06,0E.
- Blanking: digit i shows 7'h7F (`an` still asserted) when either condition holds:
  - `active` blank bit i is set.
  - `lz_en`=1, i>0, and all active nibbles at index ≥ i are zero. Digit 0 is never LZ-blanked.
- Update handshake:
  - Accept occurs when `upd_valid` and `upd_ready` are both high at a clock edge.
  - `upd_ready` = !pending.
  - Accept on a non-boundary cycle: data goes to `pending`, and pending←1.
  - At a frame boundary (`frame_tick` cycle) with pending=1: `active`←`pending` and pending←0.
  - Accept on the boundary cycle itself: data goes directly to `active`, and pending stays 0.
  - `upd_valid` while `upd_ready`=0 is held off. The producer keeps it asserted; it is not dropped.
- Reset (async, rst_n=0):
  - `an`=4'b1111, `sseg`=7'h7F, `frame_tick`=0, `upd_ready`=1.
  - `active`=0, blank mask=4'b0000, pending=0, `dig`=0, `slot_cnt`=0, state GAP.
  - Reset mid-frame discards `pending` and restarts at digit 0, GAP.

## Timing
- `an`, `sseg` and `frame_tick` are registered. They reflect the state/counter values of the previous cycle: one-cycle output latency.
- The first digit-0 DRIVE appears on `an` at cycle GAP_CYCLES+1 after rst_n deasserts.
- Frame period is 4·SLOT_CYCLES. `frame_tick` period is exactly 4·SLOT_CYCLES cycles.
- Non-boundary update latency: new digits become visible on the slot following the next boundary, i.e. digit 0 of the next frame.
- Boundary-cycle update: visible in the immediately following frame.
- `upd_ready` falls the cycle after an accept. It rises the cycle after the boundary that drains `pending`.
- `lz_en` changes take effect on the next slot's DRIVE output with no frame alignment.
- `an` never has more than one bit low. Every transition between two different low bits passes through ≥GAP_CYCLES of 4'b1111.

## Structure
- Package `sseg_pkg`:
  - `SSEG_BLANK`=7'h7F and `AN_OFF`=4'b1111.
  - The 16-entry hex-to-segment constant table.
  - `typedef enum logic {GAP, DRIVE} scan_state_t`.
  - `typedef struct packed {logic [15:0] data; logic [3:0] blank;} disp_frame_t`.
- One sub-module, `sseg_hex_decode`: a combinational nibble→7-bit active-low segments decoder using the package table. It is reused by other display blocks.
- Scan FSM, counters, shadow buffer and LZ logic stay in `sseg_scan_ctrl`.

## Test plan
All scenarios use SLOT_CYCLES=8 and GAP_CYCLES=2.
- Reset, then idle 40 cycles:
  - During reset `an`=1111 and `sseg`=7F.
  - Afterwards `an` cycles 1110→1101→1011→0111 with 2-cycle 1111 gaps.
  - `sseg`=40 in every DRIVE.
  - `frame_tick` appears every 32 cycles.
- Accept `upd_data`=16'h12C9 mid-frame:
  - `upd_ready`=0 until the boundary.
  - The next frame shows digits 0..3 = 10,46,24,79.
  - `upd_ready` returns to 1.
- Two back-to-back offers, 16'h0004 then 16'h0E00:
  - The second is held with `upd_ready`=0 and is accepted the cycle after the drain.
  - Each value is displayed for at least one whole frame, with no frame mixing nibbles of both.
- `lz_en`=1 with data 16'h0040:
  - Digits 3 and 2 are blank (7F, `an` still scanning).
  - Digit 1 = 19 and digit 0 = 40.
  - Data 16'h0000 shows only digit 0 = 40.
- Offer aligned to the `frame_tick` cycle with 16'hFFFF and `upd_blank`=4'b0100:
  - `upd_ready` stays 1.
  - The next frame shows 0E on digits 0, 1 and 3, and 7F on digit 2.
- Assert rst_n low mid-DRIVE of digit 2 with an update pending:
  - Outputs go to 1111/7F asynchronously and `upd_ready`=1.
  - After release, digit 0 shows 40 (pending discarded).
